// File: rtl/pubkey_serializer.sv
// SEC1 public-key serializer: latches an affine (X,Y) pair and streams the
// compressed (33-byte) or uncompressed (65-byte) encoding over a valid/ready byte port.
module pubkey_serializer #(
  parameter int COMPRESSED = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [255:0] pub_x,
  input  logic [255:0] pub_y,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [6:0] LAST_FULL = (COMPRESSED != 0) ? 7'd32 : 7'd64;

  state_t       state, state_nxt;
  logic [6:0]   cnt, cnt_nxt;
  logic [255:0] key_x, key_y;
  logic         up;
  logic         overrun_q;

  logic         accept;
  logic         is_inf;
  logic [6:0]   last_idx;
  logic         at_last;
  logic [6:0]   cnt_m1;
  logic [4:0]   k;
  logic [7:0]   prefix;
  logic [7:0]   byte_sel;

  // Byte k (0 = most significant) of a 256-bit big-endian field.
  function automatic logic [7:0] key_byte(input logic [255:0] key, input logic [4:0] kk);
    logic [7:0] base;
    base = {~kk, 3'b000};
    return key[base +: 8];
  endfunction

  assign accept   = in_valid && in_ready;
  assign is_inf   = (key_x == '0) && (key_y == '0);
  assign last_idx = is_inf ? 7'd0 : LAST_FULL;
  assign at_last  = (cnt == last_idx);
  assign cnt_m1   = cnt - 7'd1;
  assign k        = cnt_m1[4:0];

  always_comb begin
    prefix = 8'h04;
    if (is_inf)
      prefix = 8'h00;
    else if (COMPRESSED != 0)
      prefix = {7'b0000001, key_y[0]};
  end

  always_comb begin
    byte_sel = prefix;
    if (cnt != 7'd0) begin
      if (cnt <= 7'd32) byte_sel = key_byte(key_x, k);
      else              byte_sel = key_byte(key_y, k);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEND;
          cnt_nxt   = 7'd0;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (at_last) begin
            state_nxt = IDLE;
            cnt_nxt   = 7'd0;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 7'd0;
      end
    endcase
  end

  // Key registers are cleared by reset so an aborted frame leaves no stale key behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 7'd0;
      key_x     <= '0;
      key_y     <= '0;
      up        <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      up        <= 1'b1;
      overrun_q <= in_valid && !in_ready;
      if (accept) begin
        key_x <= pub_x;
        key_y <= pub_y;
      end
    end
  end

  // Outputs decode from registered state, so reset clears them without waiting for a clock.
  assign in_ready  = up && (state == IDLE);
  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && at_last;
  assign out_data  = (state == SEND) ? byte_sel : 8'h00;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pubkey_serializer.sv
// Bench for pubkey_serializer: a compressed and an uncompressed instance checked
// every cycle against a byte-frame model, plus literal checks on known encodings.
module tb_pubkey_serializer;

  localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   in_valid = 2'b00;
  logic [255:0] pub_x = '0;
  logic [255:0] pub_y = '0;
  logic         out_ready = 1'b1;
  logic [1:0]   in_ready_w, out_valid_w, out_last_w, overrun_w;
  logic [1:0][7:0] od;

  int n_tests = 0;
  int n_fail  = 0;

  // model state, index 0 = compressed instance, 1 = uncompressed
  logic [7:0] m_frame [2][65];
  int         m_len [2];
  int         m_pos [2];
  bit         m_busy [2];
  bit         m_ovr [2];
  bit         m_up;
  bit         prev_stall [2];
  logic [7:0] prev_data [2];

  logic [7:0] rec [2][80];
  int         rec_n [2];
  int         done_n [2];
  int         ovr_n [2];

  always #5 clk = ~clk;

  pubkey_serializer #(.COMPRESSED(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .pub_x(pub_x), .pub_y(pub_y),
    .in_ready(in_ready_w[0]), .out_data(od[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .out_last(out_last_w[0]), .overrun(overrun_w[0])
  );

  pubkey_serializer #(.COMPRESSED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .pub_x(pub_x), .pub_y(pub_y),
    .in_ready(in_ready_w[1]), .out_data(od[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .out_last(out_last_w[1]), .overrun(overrun_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void encode(input int d, input logic [255:0] x, input logic [255:0] y);
    logic [255:0] t;
    if (x == '0 && y == '0) begin
      m_frame[d][0] = 8'h00;
      m_len[d] = 1;
    end else begin
      if (d == 0) m_frame[d][0] = y[0] ? 8'h03 : 8'h02;
      else        m_frame[d][0] = 8'h04;
      for (int i = 0; i < 32; i++) begin
        t = x >> (8 * (31 - i));
        m_frame[d][1 + i] = t[7:0];
        t = y >> (8 * (31 - i));
        if (d == 1) m_frame[d][33 + i] = t[7:0];
      end
      m_len[d] = (d == 0) ? 33 : 65;
    end
  endfunction

  // Compare and model update at the falling edge; inputs are stable here until after the next rising edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit exp_rdy;
      if (rst) begin
        m_busy[d] = 0; m_pos[d] = 0; m_ovr[d] = 0; m_up = 0; prev_stall[d] = 0;
      end
      exp_rdy = m_up && !m_busy[d];
      chk(d == 0 ? "in_ready_c" : "in_ready_u", 32'(in_ready_w[d]), 32'(exp_rdy));
      chk(d == 0 ? "out_valid_c" : "out_valid_u", 32'(out_valid_w[d]), 32'(m_busy[d]));
      chk(d == 0 ? "out_data_c" : "out_data_u", 32'(od[d]),
          m_busy[d] ? 32'(m_frame[d][m_pos[d]]) : 32'h0);
      chk(d == 0 ? "out_last_c" : "out_last_u", 32'(out_last_w[d]),
          32'(m_busy[d] && (m_pos[d] == m_len[d] - 1)));
      chk(d == 0 ? "overrun_c" : "overrun_u", 32'(overrun_w[d]), 32'(m_ovr[d]));
      if (prev_stall[d] && !rst)
        chk("stall_stable", 32'(od[d]), 32'(prev_data[d]));
      if (!rst) begin
        if (overrun_w[d]) ovr_n[d]++;
        if (out_valid_w[d] && out_ready) begin
          if (rec_n[d] < 80) rec[d][rec_n[d]] = od[d];
          rec_n[d]++;
          if (out_last_w[d]) done_n[d]++;
        end
        prev_stall[d] = out_valid_w[d] && !out_ready;
        prev_data[d]  = od[d];
        m_ovr[d] = in_valid[d] && !exp_rdy;
        if (!m_busy[d] && in_valid[d] && exp_rdy) begin
          encode(d, pub_x, pub_y);
          m_busy[d] = 1;
          m_pos[d]  = 0;
        end else if (m_busy[d] && out_ready) begin
          m_pos[d]++;
          if (m_pos[d] == m_len[d]) m_busy[d] = 0;
        end
      end
    end
    if (!rst) m_up = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      rec_n[d] = 0; done_n[d] = 0; ovr_n[d] = 0;
    end
  endtask

  task automatic send(input int d, input logic [255:0] x, input logic [255:0] y);
    int i;
    i = 0;
    while (!in_ready_w[d] && i < 200) begin tick(); i++; end
    chk("send_ready_wait", 32'(in_ready_w[d]), 32'h1);
    pub_x = x; pub_y = y;
    in_valid[d] = 1'b1;
    tick();
    in_valid[d] = 1'b0;
    pub_x = ~x; pub_y = ~y;
  endtask

  task automatic wait_done(input int d, input int target, input bit rnd);
    for (int i = 0; i < 2000 && done_n[d] < target; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    chk("frame_done", 32'(done_n[d]), 32'(target));
  endtask

  initial begin
    clear_stats();
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready_w), 32'h0);
    chk("rst_out_valid", 32'(out_valid_w), 32'h0);
    rst = 1'b0;
    chk("ready_before_edge", 32'(in_ready_w), 32'h0);
    tick();
    chk("ready_after_rst", 32'(in_ready_w), 32'h3);

    // compressed G
    clear_stats();
    send(0, GX, GY);
    wait_done(0, 1, 0);
    tick();
    chk("g_c_ready_after", 32'(in_ready_w[0]), 32'h1);
    chk("g_c_len", 32'(rec_n[0]), 32'd33);
    chk("g_c_b0", 32'(rec[0][0]), 32'h02);
    chk("g_c_b1", 32'(rec[0][1]), 32'h79);
    chk("g_c_b2", 32'(rec[0][2]), 32'hBE);
    chk("g_c_b31", 32'(rec[0][31]), 32'h17);
    chk("g_c_b32", 32'(rec[0][32]), 32'h98);

    // uncompressed G
    clear_stats();
    send(1, GX, GY);
    wait_done(1, 1, 0);
    chk("g_u_len", 32'(rec_n[1]), 32'd65);
    chk("g_u_b0", 32'(rec[1][0]), 32'h04);
    chk("g_u_b32", 32'(rec[1][32]), 32'h98);
    chk("g_u_b33", 32'(rec[1][33]), 32'h48);
    chk("g_u_b34", 32'(rec[1][34]), 32'h3A);
    chk("g_u_b64", 32'(rec[1][64]), 32'hB8);

    // odd Y, X = 1
    clear_stats();
    send(0, 256'h1, 256'h1);
    wait_done(0, 1, 0);
    chk("odd_len", 32'(rec_n[0]), 32'd33);
    chk("odd_b0", 32'(rec[0][0]), 32'h03);
    chk("odd_b1", 32'(rec[0][1]), 32'h00);
    chk("odd_b31", 32'(rec[0][31]), 32'h00);
    chk("odd_b32", 32'(rec[0][32]), 32'h01);

    // random backpressure
    clear_stats();
    send(0, GX, GY);
    wait_done(0, 1, 1);
    chk("bp_len", 32'(rec_n[0]), 32'd33);
    chk("bp_b0", 32'(rec[0][0]), 32'h02);
    chk("bp_b1", 32'(rec[0][1]), 32'h79);
    chk("bp_b32", 32'(rec[0][32]), 32'h98);

    // overrun at byte 10 and on the final handshake
    clear_stats();
    tick();
    send(0, GX, GY);
    for (int i = 0; i < 100 && rec_n[0] < 10; i++) tick();
    pub_x = 256'h5; pub_y = 256'h7;
    in_valid[0] = 1'b1; tick(); in_valid[0] = 1'b0;
    for (int i = 0; i < 100 && !out_last_w[0]; i++) tick();
    chk("ovr_at_last", 32'(out_last_w[0]), 32'h1);
    in_valid[0] = 1'b1; tick(); in_valid[0] = 1'b0;
    tick(); tick(); tick();
    chk("ovr_pulses", 32'(ovr_n[0]), 32'd2);
    chk("ovr_frames", 32'(done_n[0]), 32'd1);
    chk("ovr_len", 32'(rec_n[0]), 32'd33);
    chk("ovr_b32", 32'(rec[0][32]), 32'h98);
    chk("ovr_no_new", 32'(out_valid_w[0]), 32'h0);

    // reset mid-frame, then point at infinity on both instances
    clear_stats();
    send(0, GX, GY);
    for (int i = 0; i < 100 && rec_n[0] < 20; i++) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid_w[0]), 32'h0);
    chk("rst_mid_data", 32'(od[0]), 32'h0);
    tick();
    rst = 1'b0;
    chk("rst_mid_count", 32'(rec_n[0]), 32'd20);
    clear_stats();
    send(0, '0, '0);
    wait_done(0, 1, 0);
    chk("inf_c_len", 32'(rec_n[0]), 32'd1);
    chk("inf_c_b0", 32'(rec[0][0]), 32'h00);
    send(1, '0, '0);
    wait_done(1, 1, 0);
    chk("inf_u_len", 32'(rec_n[1]), 32'd1);
    chk("inf_u_b0", 32'(rec[1][0]), 32'h00);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pubkey_serializer.md
PUBKEY_SERIALIZER -- requirements
Module: pubkey_serializer

Interface
REQ-001 The block SHALL have parameter COMPRESSED, default 1, meaning 1 = 33-byte SEC1 compressed encoding and 0 = 65-byte SEC1 uncompressed encoding.
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port in_valid  input  1  one-cycle pulse marking pub_x/pub_y valid (driven by the scalar multiplier done).
REQ-005 Port pub_x  input  256  affine X of public key.
REQ-006 Port pub_y  input  256  affine Y of public key.
REQ-007 Port in_ready  output  1  high when a new key can be accepted.
REQ-008 Port out_data  output  8  serialized byte.
REQ-009 Port out_valid  output  1  out_data valid.
REQ-010 Port out_ready  input  1  downstream accepts the byte.
REQ-011 Port out_last  output  1  marks the final byte of the encoding.
REQ-012 Port overrun  output  1  one-cycle pulse when in_valid arrives while in_ready is low.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE (in_ready=1, out_valid=0) and SEND (in_ready=0, out_valid=1).
REQ-014 IDLE->SEND SHALL occur on in_valid=1; pub_x and pub_y are latched into internal 256-bit registers in that same cycle.
REQ-015 out_valid SHALL rise on the first cycle after acceptance, giving a latency of 1 cycle from in_valid to the first byte.
REQ-016 A byte transfers only on the out_valid&&out_ready cycle; the byte counter then increments, starting from 0.
REQ-017 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-018 Byte 0 SHALL be the prefix:
- COMPRESSED=1: 0x02 if latched Y[0]=0, else 0x03.
- COMPRESSED=0: 0x04.
REQ-019 Bytes 1..32 SHALL be X in big-endian order: byte 1 = X[255:248], byte 32 = X[7:0].
REQ-020 When COMPRESSED=0, bytes 33..64 SHALL be Y in big-endian order, formatted like X.
REQ-021 out_last SHALL be high only on the final byte: byte 32 (compressed) or byte 64 (uncompressed).
REQ-022 If the latched X=0 and Y=0 (point at infinity), the block SHALL emit the single byte 0x00 with out_last=1, in either mode.
REQ-023 On the handshake of the out_last byte, the FSM SHALL return to IDLE; in_ready is high on the next cycle.
REQ-024 With out_ready held at 1, one byte transfers per cycle; a full frame takes 33 or 65 cycles back-to-back.
REQ-025 If in_valid=1 while in SEND, including the cycle of the final byte handshake, the input SHALL be ignored and overrun SHALL pulse on the next cycle.
REQ-026 Latched key registers SHALL NOT change during SEND, whatever pub_x/pub_y do.
REQ-027 The byte counter SHALL be 7 bits wide and SHALL never exceed the final index.

Reset
REQ-028 On rst=1, all outputs SHALL clear asynchronously: in_ready=0, out_valid=0, out_last=0, out_data=0x00, overrun=0.
REQ-029 While rst=1, state SHALL be IDLE, the counter 0, and the latched key registers 0.
REQ-030 in_ready SHALL go to 1 on the first clock edge after rst deasserts.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no further bytes; the next frame starts at byte 0.

Verification
REQ-032 COMPRESSED=1, out_ready=1, key=G (X=79BE667E...16F81798, Y=483ADA77...FB10D4B8):
- required: 33 consecutive bytes 02,79,BE,...,17,98.
- out_last only on 0x98.
- in_ready high the cycle after.
REQ-033 COMPRESSED=0, same G:
- required: 65 bytes 04, X bytes, then 48,3A,...,D4,B8.
- out_last only on 0xB8.
REQ-034 COMPRESSED=1, Y=...01 (odd), X=0x00..01:
- required: prefix 03.
- bytes 1..31 = 00, byte 32 = 01.
REQ-035 out_ready toggled pseudo-randomly (about 50%):
- required: byte sequence identical to REQ-032.
- out_data stable during every stall.
REQ-036 in_valid pulsed at byte 10 of a frame and again on the last-byte handshake cycle:
- required: two overrun pulses.
- current frame uncorrupted.
- no new frame started.
REQ-037 rst pulsed at byte 20:
- required: out_valid=0 immediately.
- a subsequent in_valid with X=Y=0 yields the single byte 00 with out_last=1.
